ibutterfly8_stream: RTL and testbench

Streaming inverse radix-2 butterfly stage for the 8-point level of the fft16 datapath. It accepts one complex sample per cycle over a valid/ready handshake and buffers the four upper samples (a..d) of each 8-sample group. As each lower sample (e..h) arrives, it is multiplied by the conjugate Q7 twiddle W8^-k, and the block emits the sum immediately while storing the difference. The differences are drained after the sums. This block is the inverse-transform counterpart of the combinational forward butterfly8 and is used on the IFFT return path.

---
 rtl/ibfly8_pkg.sv | 36 +++
 rtl/cmul_q7.sv | 21 ++
 rtl/ibutterfly8_stream.sv | 158 +++++++++++++++
 tb/tb_ibutterfly8_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibfly8_pkg.sv
// Shared constants and types for the streaming inverse radix-2 8-point butterfly.
// Holds the conjugate Q7 twiddles, the Q7 scale and the FSM state encoding.
package ibfly8_pkg;

    localparam int GROUP_SIZE = 8;
    localparam int LANES      = GROUP_SIZE / 2;

    localparam logic signed [63:0] Q7_SCALE  = 64'sd128;
    localparam int                 OUT_SHIFT = 8;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BFLY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Conjugate twiddles W8^-k in Q7
    function automatic logic signed [31:0] tw_re(input logic [1:0] k);
        case (k)
            2'd0:    return 32'sd128;
            2'd1:    return 32'sd90;
            2'd2:    return 32'sd0;
            default: return -32'sd90;
        endcase
    endfunction

    function automatic logic signed [31:0] tw_im(input logic [1:0] k);
        case (k)
            2'd0:    return 32'sd0;
            2'd1:    return 32'sd90;
            2'd2:    return 32'sd128;
            default: return 32'sd90;
        endcase
    endfunction

endpackage

// File: rtl/cmul_q7.sv
// Combinational complex multiply of a 64-bit sample by a 32-bit Q7 twiddle.
// Results wrap to 64 bits; the twiddle is sign-extended before multiplying.
module cmul_q7 (
    input  logic signed [63:0] i_x_re,
    input  logic signed [63:0] i_x_im,
    input  logic signed [31:0] i_t_re,
    input  logic signed [31:0] i_t_im,
    output logic signed [63:0] o_re,
    output logic signed [63:0] o_im
);

    logic signed [63:0] w_t_re;
    logic signed [63:0] w_t_im;

    assign w_t_re = 64'(i_t_re);
    assign w_t_im = 64'(i_t_im);

    assign o_re = (i_x_re * w_t_re) - (i_x_im * w_t_im);
    assign o_im = (i_x_re * w_t_im) + (i_x_im * w_t_re);

endmodule

// File: rtl/ibutterfly8_stream.sv
// Streaming inverse radix-2 butterfly for the 8-point level of the fft16 IFFT path.
// Optional macro IBFLY8_SCALE_EN: shift every output component right by 8 (Q7 removal plus 1/2).
import ibfly8_pkg::*;

module ibutterfly8_stream (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [63:0] in_real,
    input  logic signed [63:0] in_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [63:0] out_real,
    output logic signed [63:0] out_im,
    output logic               out_last
);

    state_t             r_state;
    logic [1:0]         r_idx;

    logic signed [63:0] r_upper_re [LANES];
    logic signed [63:0] r_upper_im [LANES];
    logic signed [63:0] r_diff_re  [LANES];
    logic signed [63:0] r_diff_im  [LANES];

    logic               r_out_valid;
    logic signed [63:0] r_out_real;
    logic signed [63:0] r_out_im;
    logic               r_out_last;

    logic               w_out_free;
    logic               w_accept;
    logic signed [63:0] w_tw_re;
    logic signed [63:0] w_tw_im;
    logic signed [63:0] w_up_re;
    logic signed [63:0] w_up_im;
    logic signed [63:0] w_sum_raw_re;
    logic signed [63:0] w_sum_raw_im;
    logic signed [63:0] w_diff_raw_re;
    logic signed [63:0] w_diff_raw_im;
    logic signed [63:0] w_sum_re;
    logic signed [63:0] w_sum_im;
    logic signed [63:0] w_diff_re;
    logic signed [63:0] w_diff_im;

    assign out_valid = r_out_valid;
    assign out_real  = r_out_real;
    assign out_im    = r_out_im;
    assign out_last  = r_out_last;

    assign w_out_free = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    // Single output register, so BFLY can only accept when that register frees up
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            LOAD:    in_ready = 1'b1;
            BFLY:    in_ready = w_out_free;
            default: in_ready = 1'b0;
        endcase
    end

    cmul_q7 u_cmul (
        .i_x_re (in_real),
        .i_x_im (in_im),
        .i_t_re (tw_re(r_idx)),
        .i_t_im (tw_im(r_idx)),
        .o_re   (w_tw_re),
        .o_im   (w_tw_im)
    );

    assign w_up_re       = r_upper_re[r_idx] * Q7_SCALE;
    assign w_up_im       = r_upper_im[r_idx] * Q7_SCALE;
    assign w_sum_raw_re  = w_up_re + w_tw_re;
    assign w_sum_raw_im  = w_up_im + w_tw_im;
    assign w_diff_raw_re = w_up_re - w_tw_re;
    assign w_diff_raw_im = w_up_im - w_tw_im;

`ifdef IBFLY8_SCALE_EN
    assign w_sum_re  = w_sum_raw_re  >>> OUT_SHIFT;
    assign w_sum_im  = w_sum_raw_im  >>> OUT_SHIFT;
    assign w_diff_re = w_diff_raw_re >>> OUT_SHIFT;
    assign w_diff_im = w_diff_raw_im >>> OUT_SHIFT;
`else
    assign w_sum_re  = w_sum_raw_re;
    assign w_sum_im  = w_sum_raw_im;
    assign w_diff_re = w_diff_raw_re;
    assign w_diff_im = w_diff_raw_im;
`endif

    // A consumed output clears valid; any load in the same cycle overrides it below
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_idx       <= 2'd0;
            r_out_valid <= 1'b0;
            r_out_real  <= '0;
            r_out_im    <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_upper_re[i] <= '0;
                r_upper_im[i] <= '0;
                r_diff_re[i]  <= '0;
                r_diff_im[i]  <= '0;
            end
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_upper_re[r_idx] <= in_real;
                        r_upper_im[r_idx] <= in_im;
                        r_idx             <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= BFLY;
                        end
                    end
                end
                BFLY: begin
                    if (w_accept) begin
                        r_out_real       <= w_sum_re;
                        r_out_im         <= w_sum_im;
                        r_out_valid      <= 1'b1;
                        r_out_last       <= 1'b0;
                        r_diff_re[r_idx] <= w_diff_re;
                        r_diff_im[r_idx] <= w_diff_im;
                        r_idx            <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_free) begin
                        r_out_real  <= r_diff_re[r_idx];
                        r_out_im    <= r_diff_im[r_idx];
                        r_out_valid <= 1'b1;
                        r_out_last  <= (r_idx == 2'd3);
                        r_idx       <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_state <= LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= LOAD;
                    r_idx   <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibutterfly8_stream.sv
// Directed self-checking bench for ibutterfly8_stream.
// Expected values are hand-computed raw results, passed through scl() when IBFLY8_SCALE_EN is defined.
module tb_ibutterfly8_stream;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [63:0] in_real;
    logic signed [63:0] in_im;
    logic               out_valid;
    logic               out_ready;
    logic signed [63:0] out_real;
    logic signed [63:0] out_im;
    logic               out_last;

    int passCount  = 0;
    int checkCount = 0;

    logic signed [63:0] srcRe[$];
    logic signed [63:0] srcIm[$];
    logic signed [63:0] gotRe[$];
    logic signed [63:0] gotIm[$];
    logic               gotLast[$];

    ibutterfly8_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_im    (out_im),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [63:0] scl(input logic signed [63:0] v);
`ifdef IBFLY8_SCALE_EN
        return v >>> 8;
`else
        return v;
`endif
    endfunction

    task automatic load_src(input logic signed [63:0] re[8], input logic signed [63:0] im[8]);
        for (int i = 0; i < 8; i++) begin
            srcRe.push_back(re[i]);
            srcIm.push_back(im[i]);
        end
    endtask

    // Drive srcRe/srcIm and collect nOut transfers; stallChk adds hold and in_ready checks
    task automatic run_stream(input int nOut, input logic [3:0] readyPat, input bit stallChk,
                              input int maxCyc);
        int                 ptr = 0;
        int                 cyc = 0;
        bit                 prevStall = 0;
        logic signed [63:0] hRe = '0;
        logic signed [63:0] hIm = '0;
        logic               hLast = 1'b0;
        gotRe.delete();
        gotIm.delete();
        gotLast.delete();
        while (gotRe.size() < nOut && cyc < maxCyc) begin
            @(posedge clk);
            #1;
            out_ready = readyPat[cyc % 4];
            if (ptr < srcRe.size()) begin
                in_valid = 1'b1;
                in_real  = srcRe[ptr];
                in_im    = srcIm[ptr];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (stallChk) begin
                if (prevStall) begin
                    checkCount++;
                    if (out_valid !== 1'b1 || out_real !== hRe || out_im !== hIm || out_last !== hLast)
                        $display("[TB] FAIL stall_hold: got v=%0b (%0d,%0d) last=%0b expected v=1 (%0d,%0d) last=%0b",
                                 out_valid, out_real, out_im, out_last, hRe, hIm, hLast);
                    else
                        passCount++;
                end
                if (ptr < srcRe.size() && (ptr % 8) >= 4) begin
                    checkCount++;
                    if (in_ready !== (!out_valid || out_ready))
                        $display("[TB] FAIL bfly_in_ready: got %0b expected %0b", in_ready,
                                 !out_valid || out_ready);
                    else
                        passCount++;
                end
            end
            prevStall = out_valid && !out_ready;
            hRe       = out_real;
            hIm       = out_im;
            hLast     = out_last;
            if (in_valid && in_ready) ptr++;
            if (out_valid && out_ready) begin
                gotRe.push_back(out_real);
                gotIm.push_back(out_im);
                gotLast.push_back(out_last);
            end
            cyc++;
        end
        in_valid = 1'b0;
        checkCount++;
        if (gotRe.size() != nOut)
            $display("[TB] FAIL stream_timeout: got %0d outputs expected %0d", gotRe.size(), nOut);
        else
            passCount++;
        srcRe.delete();
        srcIm.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_real   = '0;
        in_im     = '0;
        out_ready = 1'b1;
        #23;
        checkCount++;
        if (out_valid !== 1'b0 || out_real !== 64'sd0 || out_im !== 64'sd0 || out_last !== 1'b0)
            $display("[TB] FAIL reset_outputs: got v=%0b (%0d,%0d) last=%0b expected v=0 (0,0) last=0",
                     out_valid, out_real, out_im, out_last);
        else
            passCount++;
        checkCount++;
        if (in_ready !== 1'b1)
            $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready);
        else
            passCount++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        logic signed [63:0] re[8] = '{64'sd1, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] expRe[8] = '{scl(128), 0, 0, 0, scl(128), 0, 0, 0};
        load_src(re, im);
        run_stream(8, 4'b1111, 1'b0, 100);
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (gotRe[i] !== expRe[i] || gotIm[i] !== 64'sd0 || gotLast[i] !== (i == 7))
                $display("[TB] FAIL impulse[%0d]: got (%0d,%0d) last=%0b expected (%0d,0) last=%0b",
                         i, gotRe[i], gotIm[i], gotLast[i], expRe[i], i == 7);
            else
                passCount++;
        end
    endtask

    task automatic test_twiddle(input logic [3:0] readyPat, input bit stallChk, input string name);
        logic signed [63:0] re[8] = '{0, 0, 0, 0, 64'sd1, 64'sd1, 64'sd0, 64'sd1};
        logic signed [63:0] im[8] = '{0, 0, 0, 0, 64'sd0, 64'sd0, 64'sd1, 64'sd0};
        logic signed [63:0] expRe[8] = '{scl(128), scl(90), scl(-128), scl(-90),
                                         scl(-128), scl(-90), scl(128), scl(90)};
        logic signed [63:0] expIm[8] = '{scl(0), scl(90), scl(0), scl(90),
                                         scl(0), scl(-90), scl(0), scl(-90)};
        load_src(re, im);
        run_stream(8, readyPat, stallChk, 200);
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (gotRe[i] !== expRe[i] || gotIm[i] !== expIm[i] || gotLast[i] !== (i == 7))
                $display("[TB] FAIL %s[%0d]: got (%0d,%0d) last=%0b expected (%0d,%0d) last=%0b",
                         name, i, gotRe[i], gotIm[i], gotLast[i], expRe[i], expIm[i], i == 7);
            else
                passCount++;
        end
    endtask

    task automatic test_reset_mid_group();
        int accepted = 0;
        int cyc = 0;
        logic signed [63:0] re[8] = '{64'sd5, 64'sd6, 64'sd7, 64'sd8, 64'sd1, 64'sd2, 64'sd3, 64'sd4};
        out_ready = 1'b1;
        while (accepted < 6 && cyc < 40) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_real  = re[accepted];
            in_im    = '0;
            @(negedge clk);
            if (in_ready) accepted++;
            cyc++;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checkCount++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL mid_reset: got out_valid=%0b in_ready=%0b expected out_valid=0 in_ready=1",
                     out_valid, in_ready);
        else
            passCount++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_twiddle(4'b1111, 1'b0, "after_reset");
    endtask

    task automatic test_wrap();
        logic signed [63:0] re[8] = '{64'sh0100_0000_0000_0000, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] big = scl(64'sh8000_0000_0000_0000);
        load_src(re, im);
        run_stream(8, 4'b1111, 1'b0, 100);
        checkCount++;
        if (gotRe[0] !== big || gotRe[4] !== big)
            $display("[TB] FAIL wrap: got a'=%0h e'=%0h expected %0h", gotRe[0], gotRe[4], big);
        else
            passCount++;
    endtask

    task automatic test_back_to_back();
        int lastCount = 0;
        logic signed [63:0] re1[8] = '{64'sd1, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] im1[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] re2[8] = '{0, 0, 0, 0, 64'sd1, 64'sd1, 64'sd0, 64'sd1};
        logic signed [63:0] im2[8] = '{0, 0, 0, 0, 64'sd0, 64'sd0, 64'sd1, 64'sd0};
        logic signed [63:0] re3[8] = '{64'sd1, 64'sd2, 0, 0, 0, 0, 64'sd1, 0};
        logic signed [63:0] im3[8] = '{64'sd1, 0, 0, -64'sd1, 0, 64'sd1, 64'sd1, 0};
        logic signed [63:0] expRe[24] = '{
            scl(128), 0, 0, 0, scl(128), 0, 0, 0,
            scl(128), scl(90), scl(-128), scl(-90), scl(-128), scl(-90), scl(128), scl(90),
            scl(128), scl(166), scl(-128), scl(0), scl(128), scl(346), scl(128), scl(0)};
        logic signed [63:0] expIm[24] = '{
            0, 0, 0, 0, 0, 0, 0, 0,
            scl(0), scl(90), scl(0), scl(90), scl(0), scl(-90), scl(0), scl(-90),
            scl(128), scl(90), scl(128), scl(-128), scl(128), scl(-90), scl(-128), scl(-128)};
        load_src(re1, im1);
        load_src(re2, im2);
        load_src(re3, im3);
        run_stream(24, 4'b1111, 1'b0, 300);
        for (int i = 0; i < 24; i++) begin
            checkCount++;
            if (gotRe[i] !== expRe[i] || gotIm[i] !== expIm[i] || gotLast[i] !== (i % 8 == 7))
                $display("[TB] FAIL b2b[%0d]: got (%0d,%0d) last=%0b expected (%0d,%0d) last=%0b",
                         i, gotRe[i], gotIm[i], gotLast[i], expRe[i], expIm[i], i % 8 == 7);
            else
                passCount++;
            if (gotLast[i] === 1'b1) lastCount++;
        end
        checkCount++;
        if (lastCount != 3)
            $display("[TB] FAIL b2b_last_count: got %0d expected 3", lastCount);
        else
            passCount++;
    endtask

`ifdef IBFLY8_SCALE_EN
    task automatic test_scale();
        logic signed [63:0] re[8] = '{64'sd256, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] neg[8] = '{-64'sd2, 0, 0, 0, 0, 0, 0, 0};
        logic signed [63:0] im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        load_src(re, im);
        run_stream(8, 4'b1111, 1'b0, 100);
        checkCount++;
        if (gotRe[0] !== 64'sd128 || gotRe[4] !== 64'sd128)
            $display("[TB] FAIL scale_impulse: got a'=%0d e'=%0d expected 128", gotRe[0], gotRe[4]);
        else
            passCount++;
        load_src(neg, im);
        run_stream(8, 4'b1111, 1'b0, 100);
        checkCount++;
        if (gotRe[0] !== -64'sd1 || gotRe[4] !== -64'sd1)
            $display("[TB] FAIL scale_neg: got a'=%0d e'=%0d expected -1", gotRe[0], gotRe[4]);
        else
            passCount++;
    endtask
`endif

    initial begin
        test_reset();
        test_impulse();
        test_twiddle(4'b1111, 1'b1, "twiddle");
        test_twiddle(4'b1001, 1'b1, "backpressure");
        test_reset_mid_group();
        test_wrap();
        test_back_to_back();
`ifdef IBFLY8_SCALE_EN
        test_scale();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
